sdram_arbiter: RTL

//  Owns the single port of the SDRAM controller and shares it between mem-init, frame reader (FR) and

---
 rtl/sdram_arb_pkg.sv | 31 +++
 rtl/sdram_arb_tracker.sv | 59 +++++
 rtl/sdram_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared definitions for the SDRAM port arbiter.
//   - SDRAM command codes seen on the controller bus
//   - arbiter state encoding
//   - owner tag used to steer completions back to the issuing requester
package sdram_arb_pkg;

  localparam logic [1:0] CMD_NOP     = 2'd0;
  localparam logic [1:0] CMD_READ    = 2'd1;
  localparam logic [1:0] CMD_WRITE   = 2'd2;
  localparam logic [1:0] CMD_REFRESH = 2'd3;

  // Outstanding-read counter width; generous enough that a long granted
  // streak of back-to-back reads cannot wrap it.
  localparam int OUT_W = 16;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_GNT_FR,
    ST_GNT_PR,
    ST_DRAIN
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_MI,
    OWN_FR,
    OWN_PR
  } owner_t;

endpackage

// File: rtl/sdram_arb_tracker.sv
// sdram_arb_tracker: bookkeeping of in-flight SDRAM transactions.
//   i_Cmd              command being registered toward the controller this cycle
//   i_Owner            requester that owns i_Cmd
//   i_Data_Read_Valid  read beat from controller
//   i_Data_Write_Done  write completion from controller
//   o_Boundary         nothing in flight and nothing issued this cycle
//   o_Read_Valid       read beat that belongs to a tracked burst
//   o_Write_Done       write completion that matches a pending write
//   o_Owner            owner recorded at the last issue (completion steering)
module sdram_arb_tracker
  import sdram_arb_pkg::*;
#(
  parameter int READ_BURST_LENGTH = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [1:0] i_Cmd,
  input  owner_t     i_Owner,
  input  logic       i_Data_Read_Valid,
  input  logic       i_Data_Write_Done,
  output logic       o_Boundary,
  output logic       o_Read_Valid,
  output logic       o_Write_Done,
  output owner_t     o_Owner
);

  logic [OUT_W-1:0] r_count;
  logic             r_wr_pend;
  owner_t           r_owner;

  logic             w_issue;
  logic             w_rd_dec;
  logic [OUT_W-1:0] w_add;

  assign w_issue  = (i_Cmd != CMD_NOP);
  // A beat with nothing outstanding is stray: it neither decrements nor steers.
  assign w_rd_dec = i_Data_Read_Valid && (r_count != '0);
  assign w_add    = (i_Cmd == CMD_READ) ? OUT_W'(READ_BURST_LENGTH) : '0;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_count   <= '0;
      r_wr_pend <= 1'b0;
      r_owner   <= OWN_NONE;
    end else begin
      r_count <= r_count + w_add - OUT_W'(w_rd_dec);
      // A new write outranks a same-cycle completion of the previous one.
      if (i_Cmd == CMD_WRITE)     r_wr_pend <= 1'b1;
      else if (i_Data_Write_Done) r_wr_pend <= 1'b0;
      if (w_issue) r_owner <= i_Owner;
    end
  end

  assign o_Boundary   = (r_count == '0) && !r_wr_pend && !w_issue;
  assign o_Read_Valid = w_rd_dec;
  assign o_Write_Done = i_Data_Write_Done && r_wr_pend;
  assign o_Owner      = r_owner;

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single SDRAM controller port between mem-init (MI),
// the frame reader (FR) and the fractal processor (PR).
//   i_Clk / i_Rst_n          memory clock, async active-low reset
//   i_SDRAM_Initialized      mem-init done (sticky once seen)
//   i_MI_*                   mem-init bus, passed through while in INIT
//   i_FR_Request/_Command/_Address        FR bus (reads)
//   i_PR_Request/_Command/_Address/_Write PR bus
//   i_Data_Read_Valid / i_Data_Write_Done completions from the controller
//   o_Command/_Data_Address/_Data_Write   registered bus to the controller
//   o_FR_Grant / o_PR_Grant  one-hot-or-zero grants
//   o_FR_Read_Valid / o_PR_Read_Valid / o_PR_Write_Done  steered completions
// Optional: define SDRAM_ARB_STATS_EN to add saturating wait/switch counters
//   (o_FR_Wait_Cycles, o_PR_Wait_Cycles, o_Switch_Count, CNT_W bits).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W            = 22,
  parameter int DATA_W            = 32,
  parameter int READ_BURST_LENGTH = 8,
  parameter int PR_MIN_HOLD       = 64
`ifdef SDRAM_ARB_STATS_EN
  ,
  parameter int CNT_W             = 16
`endif
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_SDRAM_Initialized,
  input  logic [1:0]        i_MI_Command,
  input  logic [ADDR_W-1:0] i_MI_Address,
  input  logic [DATA_W-1:0] i_MI_Write,
  input  logic              i_FR_Request,
  input  logic [1:0]        i_FR_Command,
  input  logic [ADDR_W-1:0] i_FR_Address,
  input  logic              i_PR_Request,
  input  logic [1:0]        i_PR_Command,
  input  logic [ADDR_W-1:0] i_PR_Address,
  input  logic [DATA_W-1:0] i_PR_Write,
  input  logic              i_Data_Read_Valid,
  input  logic              i_Data_Write_Done,
  output logic [1:0]        o_Command,
  output logic [ADDR_W-1:0] o_Data_Address,
  output logic [DATA_W-1:0] o_Data_Write,
  output logic              o_FR_Grant,
  output logic              o_PR_Grant,
  output logic              o_FR_Read_Valid,
  output logic              o_PR_Read_Valid,
  output logic              o_PR_Write_Done
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  o_FR_Wait_Cycles,
  output logic [CNT_W-1:0]  o_PR_Wait_Cycles,
  output logic [CNT_W-1:0]  o_Switch_Count
`endif
);

  localparam int HOLD_W = $clog2(PR_MIN_HOLD + 2);

  arb_state_t        r_state, w_next;
  logic [HOLD_W-1:0] r_hold;
  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_fr_grant, r_pr_grant;

  logic [1:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  owner_t            w_owner, w_tag;
  logic              w_fr_grant_d, w_pr_grant_d;
  logic              w_boundary, w_rd_valid, w_wr_done;

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_state <= ST_INIT;
    else          r_state <= w_next;
  end

  // PR hold timer: zero on the first GNT_PR cycle, saturates at the threshold.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)                              r_hold <= '0;
    else if (r_state != ST_GNT_PR)             r_hold <= '0;
    else if (r_hold < HOLD_W'(PR_MIN_HOLD))    r_hold <= r_hold + 1'b1;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:   if (i_SDRAM_Initialized) w_next = ST_IDLE;
      ST_IDLE:   if (i_FR_Request)        w_next = ST_GNT_FR;
                 else if (i_PR_Request)   w_next = ST_GNT_PR;
      ST_GNT_FR: if (!i_FR_Request)       w_next = ST_DRAIN;
      ST_GNT_PR: if (!i_PR_Request || (i_FR_Request && r_hold >= HOLD_W'(PR_MIN_HOLD)))
                   w_next = ST_DRAIN;
      ST_DRAIN:  if (w_boundary)          w_next = ST_IDLE;
      default:   w_next = ST_INIT;
    endcase
  end

  // Outputs: bus select follows the grant the requester can see, so a
  // requester that is not visibly granted is always forwarded as NOP.
  always_comb begin
    w_cmd   = CMD_NOP;
    w_addr  = '0;
    w_data  = '0;
    w_owner = OWN_NONE;
    if (r_state == ST_INIT) begin
      w_cmd = i_MI_Command; w_addr = i_MI_Address; w_data = i_MI_Write; w_owner = OWN_MI;
    end else if (r_fr_grant) begin
      w_cmd = i_FR_Command; w_addr = i_FR_Address; w_owner = OWN_FR;
    end else if (r_pr_grant) begin
      w_cmd = i_PR_Command; w_addr = i_PR_Address; w_data = i_PR_Write; w_owner = OWN_PR;
    end
    // Grant rises one cycle after entering GNT_* and drops on the edge into DRAIN.
    w_fr_grant_d = (r_state == ST_GNT_FR) && (w_next == ST_GNT_FR);
    w_pr_grant_d = (r_state == ST_GNT_PR) && (w_next == ST_GNT_PR);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_cmd      <= CMD_NOP;
      r_addr     <= '0;
      r_data     <= '0;
      r_fr_grant <= 1'b0;
      r_pr_grant <= 1'b0;
    end else begin
      r_cmd      <= w_cmd;
      r_addr     <= w_addr;
      r_data     <= w_data;
      r_fr_grant <= w_fr_grant_d;
      r_pr_grant <= w_pr_grant_d;
    end
  end

  sdram_arb_tracker #(
    .READ_BURST_LENGTH (READ_BURST_LENGTH)
  ) u_tracker (
    .i_Clk             (i_Clk),
    .i_Rst_n           (i_Rst_n),
    .i_Cmd             (w_cmd),
    .i_Owner           (w_owner),
    .i_Data_Read_Valid (i_Data_Read_Valid),
    .i_Data_Write_Done (i_Data_Write_Done),
    .o_Boundary        (w_boundary),
    .o_Read_Valid      (w_rd_valid),
    .o_Write_Done      (w_wr_done),
    .o_Owner           (w_tag)
  );

  assign o_Command       = r_cmd;
  assign o_Data_Address  = r_addr;
  assign o_Data_Write    = r_data;
  assign o_FR_Grant      = r_fr_grant;
  assign o_PR_Grant      = r_pr_grant;
  // Steer by the issue-time tag, not the current grant, so burst tails
  // still reach the original requester during DRAIN.
  assign o_FR_Read_Valid = w_rd_valid && (w_tag == OWN_FR);
  assign o_PR_Read_Valid = w_rd_valid && (w_tag == OWN_PR);
  assign o_PR_Write_Done = w_wr_done  && (w_tag == OWN_PR);

`ifdef SDRAM_ARB_STATS_EN
  logic [CNT_W-1:0] r_fr_wait, r_pr_wait, r_switch;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_fr_wait <= '0;
      r_pr_wait <= '0;
      r_switch  <= '0;
    end else begin
      if (r_state != ST_INIT && i_FR_Request && !r_fr_grant && r_fr_wait != '1)
        r_fr_wait <= r_fr_wait + 1'b1;
      if (r_state != ST_INIT && i_PR_Request && !r_pr_grant && r_pr_wait != '1)
        r_pr_wait <= r_pr_wait + 1'b1;
      if (r_state == ST_IDLE && w_next != ST_IDLE && r_switch != '1)
        r_switch <= r_switch + 1'b1;
    end
  end

  assign o_FR_Wait_Cycles = r_fr_wait;
  assign o_PR_Wait_Cycles = r_pr_wait;
  assign o_Switch_Count   = r_switch;
`endif

endmodule
